mem_access: RTL

- MEM stage of the 5-stage core. Consumes the EX/MEM pipeline register outputs from the execute stage.
- Runs data-memory loads and stores over a req/gnt/rvalid bus, and generates byte lanes and load extension.
- Selects the writeback source and holds the MEM/WB pipeline register.
- Drives stall_mem back to execute while a bus access is outstanding.

---
 rtl/mem_access.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM stage: data-memory load/store over req/gnt/rvalid, byte lanes, load extension, MEM/WB register.
// Latency: non-memory op 1 cycle, store >= 2 cycles, load >= 3 cycles; TIMEOUT aborts a stuck access.
// Backpressure: stall_mem holds execute while an access is outstanding. Optional MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access #(
    parameter int TIMEOUT = 255,
    parameter int TIMER_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] write_data_mem,
    input  logic [31:0] next_pc_mem,
    input  logic [1:0]  wb_sel_mem,
    input  logic [1:0]  read_width_mem,
    input  logic        read_unsigned_mem,
    input  logic        rd_en_mem,
    input  logic        mem_wrt_en_mem,
    input  logic        reg_wrt_en_mem,
    input  logic [4:0]  wrt_dst_mem,
    input  logic        rdi_mem,
    output logic        stall_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wbdata_wb,
    output logic [4:0]  wrt_dst_wb,
    output logic        reg_wrt_en_wb,
    output logic        rdi_wb,
    output logic        bus_err,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [TIMER_W-1:0] TMO_V = TIMER_W'(TIMEOUT);

    state_t             state;
    logic [TIMER_W-1:0] cnt;
    logic               acc;
    logic               tmo;
    logic               misaligned;
    logic [1:0]         off;
    logic [1:0]         eff_off;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [31:0]        sh;
    logic               sx;
    logic [31:0]        load_fmt;
    logic [31:0]        wb_val;

    assign acc = rd_en_mem | mem_wrt_en_mem;
    assign off = alu_result_mem[1:0];
    assign tmo = (TIMEOUT != 0) && (state != IDLE) && (cnt == TMO_V);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((read_width_mem == 2'b01) && off[0]) ||
                        (read_width_mem[1] && (off != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Half and word accesses snap to natural alignment; eff_off drives the load shift.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = write_data_mem;
        eff_off = 2'b00;
        case (read_width_mem)
            2'b00: begin
                be_c    = 4'b0001 << off;
                wdata_c = {4{write_data_mem[7:0]}};
                eff_off = off;
            end
            2'b01: begin
                be_c    = 4'b0011 << {off[1], 1'b0};
                wdata_c = {2{write_data_mem[15:0]}};
                eff_off = {off[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        sh = dmem_rdata >> {eff_off, 3'b000};
        sx = ~read_unsigned_mem;
        case (read_width_mem)
            2'b00:   load_fmt = {{24{sx & sh[7]}}, sh[7:0]};
            2'b01:   load_fmt = {{16{sx & sh[15]}}, sh[15:0]};
            default: load_fmt = sh;
        endcase
    end

    always_comb begin
        case (wb_sel_mem)
            2'b01:   wb_val = load_fmt;
            2'b10:   wb_val = next_pc_mem;
            default: wb_val = alu_result_mem;
        endcase
    end

    // A latched store (dmem_we=1) completes on gnt; a load waits for rvalid.
    always_comb begin
        stall_mem = 1'b0;
        case (state)
            IDLE:    stall_mem = acc & ~misaligned;
            REQ:     stall_mem = ~tmo & (~dmem_gnt | ~dmem_we);
            RESP:    stall_mem = ~tmo & ~dmem_rvalid;
            default: stall_mem = 1'b0;
        endcase
        if (!rst_n) stall_mem = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_be       <= '0;
            dmem_wdata    <= '0;
            wbdata_wb     <= '0;
            wrt_dst_wb    <= '0;
            reg_wrt_en_wb <= 1'b0;
            rdi_wb        <= 1'b0;
            bus_err       <= 1'b0;
            misalign_err  <= 1'b0;
        end else begin
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc && misaligned) begin
                        misalign_err <= 1'b1;
                    end else if (acc) begin
                        state      <= REQ;
                        cnt        <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= ~rd_en_mem;
                        dmem_addr  <= {alu_result_mem[31:2], 2'b00};
                        dmem_be    <= be_c;
                        dmem_wdata <= wdata_c;
                    end
                end
                REQ: begin
                    cnt <= cnt + TIMER_W'(1);
                    if (tmo) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                    end else if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        state    <= dmem_we ? IDLE : RESP;
                    end
                end
                RESP: begin
                    cnt <= cnt + TIMER_W'(1);
                    if (tmo) begin
                        state   <= IDLE;
                        bus_err <= 1'b1;
                    end else if (dmem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // MEM/WB: bubble while stalled, on abort and on a trapped access.
            if (stall_mem || tmo || (state == IDLE && acc && misaligned)) begin
                reg_wrt_en_wb <= 1'b0;
            end else begin
                wbdata_wb     <= (state == RESP) ? load_fmt : wb_val;
                wrt_dst_wb    <= wrt_dst_mem;
                reg_wrt_en_wb <= reg_wrt_en_mem;
                rdi_wb        <= rdi_mem;
            end
        end
    end

endmodule
